// File: rtl/vga_scan_timing.sv
// Raster timing generator: pixel counters, delay-aligned syncs, blanked RGB and the snake move strobe.
// Optional colour-bar test pattern is built in when VGA_TESTPATTERN_EN is defined.
module vga_scan_timing #(
    parameter int H_VISIBLE   = 800,
    parameter int H_FRONT     = 56,
    parameter int H_SYNC      = 120,
    parameter int H_BACK      = 64,
    parameter int V_VISIBLE   = 600,
    parameter int V_FRONT     = 37,
    parameter int V_SYNC      = 6,
    parameter int V_BACK      = 23,
    parameter int SYNC_POL    = 1,
    parameter int MOVE_FRAMES = 6
) (
    input  logic        uclk,
    input  logic        reset,
`ifdef VGA_TESTPATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [2:0]  Rin,
    input  logic [2:0]  Gin,
    input  logic [1:0]  Bin,
    output logic [10:0] PixelX,
    output logic [10:0] PixelY,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  R,
    output logic [2:0]  G,
    output logic [1:0]  B,
    output logic        video_on,
    output logic        mover,
    output logic        frame_start
);

    localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
    localparam logic [10:0] H_TOTAL   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
    localparam logic [10:0] V_TOTAL   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        SYNC_ON   = (SYNC_POL != 0);
    localparam logic [7:0]  MOVE_LAST = 8'(MOVE_FRAMES - 1);

    logic       active;
    logic       hs0;
    logic       vs0;
    logic       active_d1;
    logic       hs_d1;
    logic       vs_d1;
    logic [7:0] frame_cnt;
    logic [2:0] r_src;
    logic [2:0] g_src;
    logic [1:0] b_src;

    always_ff @(posedge uclk) begin
        if (reset) begin
            PixelX <= 11'd0;
            PixelY <= 11'd0;
        end else if (PixelX == H_TOTAL - 11'd1) begin
            PixelX <= 11'd0;
            PixelY <= (PixelY == V_TOTAL - 11'd1) ? 11'd0 : PixelY + 11'd1;
        end else begin
            PixelX <= PixelX + 11'd1;
        end
    end

    assign active = (PixelX < H_VIS) && (PixelY < V_VIS);
    assign hs0    = (PixelX >= HS_START) && (PixelX < HS_END);
    assign vs0    = (PixelY >= VS_START) && (PixelY < VS_END);

    // Gated by reset so the strobe cannot fire while the counters are held at the origin.
    assign frame_start = !reset && (PixelX == 11'd0) && (PixelY == 11'd0);
    assign mover       = frame_start && (frame_cnt == MOVE_LAST);

    always_ff @(posedge uclk) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if (frame_start) begin
            frame_cnt <= (frame_cnt == MOVE_LAST) ? 8'd0 : frame_cnt + 8'd1;
        end
    end

`ifdef VGA_TESTPATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_VISIBLE / 8);

    logic [10:0] bar_px;
    logic [2:0]  bar_idx;
    logic [2:0]  bar_d1;

    // Bar index tracked alongside PixelX so no divider is needed.
    always_ff @(posedge uclk) begin
        if (reset) begin
            bar_px  <= 11'd0;
            bar_idx <= 3'd0;
            bar_d1  <= 3'd0;
        end else begin
            bar_d1 <= bar_idx;
            if (PixelX == H_TOTAL - 11'd1) begin
                bar_px  <= 11'd0;
                bar_idx <= 3'd0;
            end else if (bar_px == BAR_W - 11'd1) begin
                bar_px  <= 11'd0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 11'd1;
            end
        end
    end

    always_comb begin
        r_src = Rin;
        g_src = Gin;
        b_src = Bin;
        if (test_mode) begin
            r_src = {3{bar_d1[2]}};
            g_src = {3{bar_d1[1]}};
            b_src = {2{bar_d1[0]}};
        end
    end
`else
    always_comb begin
        r_src = Rin;
        g_src = Gin;
        b_src = Bin;
    end
`endif

    // Second stage lands on the pins together with the RGB the game logic returned.
    always_ff @(posedge uclk) begin
        if (reset) begin
            active_d1 <= 1'b0;
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            video_on  <= 1'b0;
            hsync     <= ~SYNC_ON;
            vsync     <= ~SYNC_ON;
            R         <= 3'd0;
            G         <= 3'd0;
            B         <= 2'd0;
        end else begin
            active_d1 <= active;
            hs_d1     <= hs0;
            vs_d1     <= vs0;
            video_on  <= active_d1;
            hsync     <= hs_d1 ? SYNC_ON : ~SYNC_ON;
            vsync     <= vs_d1 ? SYNC_ON : ~SYNC_ON;
            R         <= active_d1 ? r_src : 3'd0;
            G         <= active_d1 ? g_src : 3'd0;
            B         <= active_d1 ? b_src : 2'd0;
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench for vga_scan_timing on a shrunken raster (24x12) so many frames fit in a short run.
// Exercises the colour-bar pattern as well when VGA_TESTPATTERN_EN is defined.
module tb_vga_scan_timing;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 1;
    localparam int MF = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic POLB = 1'b1;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [1:0]  b;
        logic        von;
        logic        mv;
        logic        fs;
    } obs_t;

    logic        uclk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  Rin = 3'd0;
    logic [2:0]  Gin = 3'd0;
    logic [1:0]  Bin = 2'd0;
`ifdef VGA_TESTPATTERN_EN
    logic        test_mode = 1'b0;
    logic        prev_tm = 1'b0;
`endif
    logic [10:0] PixelX, PixelY;
    logic        hsync, vsync, video_on, mover, frame_start;
    logic [2:0]  R, G;
    logic [1:0]  B;

    obs_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   k = -1;
    logic prev_rst = 1'b1;
    logic [2:0] prev_r = 3'd0, prev_g = 3'd0;
    logic [1:0] prev_b = 2'd0;
    logic count_en = 1'b0;
    int   mv_cnt = 0, fs_cnt = 0, hs_cnt = 0, vs_cnt = 0, von_cnt = 0;

    vga_scan_timing #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1), .MOVE_FRAMES(MF)
    ) dut (
        .uclk(uclk),
        .reset(reset),
`ifdef VGA_TESTPATTERN_EN
        .test_mode(test_mode),
`endif
        .Rin(Rin),
        .Gin(Gin),
        .Bin(Bin),
        .PixelX(PixelX),
        .PixelY(PixelY),
        .hsync(hsync),
        .vsync(vsync),
        .R(R),
        .G(G),
        .B(B),
        .video_on(video_on),
        .mover(mover),
        .frame_start(frame_start)
    );

    always #5 uclk = ~uclk;

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.hs = !POLB;
        o.vs = !POLB;
        return o;
    endfunction

    // Expected pins for cycle kk after release, from the raster position two cycles earlier.
    function automatic obs_t model(input int kk, input logic [2:0] pr, input logic [2:0] pg,
                                   input logic [1:0] pb, input logic ptm);
        obs_t o;
        int px, py, p;
        logic act;
        logic [2:0] bi;
        o = reset_obs();
        o.x  = 11'(kk % HT);
        o.y  = 11'((kk / HT) % VT);
        o.fs = (o.x == 11'd0) && (o.y == 11'd0);
        o.mv = o.fs && (((kk / FRAME) + 1) % MF == 0);
        if (kk >= 2) begin
            p   = kk - 2;
            px  = p % HT;
            py  = (p / HT) % VT;
            act = (px < HV) && (py < VV);
            bi  = 3'(px / (HV / 8));
            o.hs  = (px >= HV + HF && px < HV + HF + HS) ? POLB : !POLB;
            o.vs  = (py >= VV + VF && py < VV + VF + VS) ? POLB : !POLB;
            o.von = act;
            if (act) begin
                o.r = ptm ? {3{bi[2]}} : pr;
                o.g = ptm ? {3{bi[1]}} : pg;
                o.b = ptm ? {2{bi[0]}} : pb;
            end
        end
        return o;
    endfunction

    task automatic applyStimulus(input logic rst, input int ncycles);
        obs_t e;
        logic tm_used;
        for (int i = 0; i < ncycles; i++) begin
            @(posedge uclk);
            #1;
            reset = rst;
            Rin = 3'($urandom);
            Gin = 3'($urandom);
            Bin = 2'($urandom);
`ifdef VGA_TESTPATTERN_EN
            tm_used = prev_tm;
`else
            tm_used = 1'b0;
`endif
            if (prev_rst && rst) begin
                k = -1;
                e = reset_obs();
            end else begin
                k = prev_rst ? 0 : k + 1;
                e = model(k, prev_r, prev_g, prev_b, tm_used);
                if (rst) begin
                    e.fs = 1'b0;
                    e.mv = 1'b0;
                end
            end
            exp_q.push_back(e);
            prev_rst = rst;
            prev_r = Rin;
            prev_g = Gin;
            prev_b = Bin;
`ifdef VGA_TESTPATTERN_EN
            prev_tm = test_mode;
`endif
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared at the falling edge.
    always @(negedge uclk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = obs_t'({PixelX, PixelY, hsync, vsync, R, G, B, video_on, mover, frame_start});
            checks++;
            if (a !== e) begin
                failures++;
                $display("[TB] FAIL pins t=%0t: got x=%0d y=%0d hs=%b vs=%b rgb=%0d/%0d/%0d von=%b mv=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b rgb=%0d/%0d/%0d von=%b mv=%b fs=%b",
                         $time, a.x, a.y, a.hs, a.vs, a.r, a.g, a.b, a.von, a.mv, a.fs,
                         e.x, e.y, e.hs, e.vs, e.r, e.g, e.b, e.von, e.mv, e.fs);
            end
            if (count_en) begin
                mv_cnt  += int'(mover);
                fs_cnt  += int'(frame_start);
                hs_cnt  += int'(hsync);
                vs_cnt  += int'(vsync);
                von_cnt += int'(video_on);
            end
        end
    end

    initial begin
        $display("[TB] reset held 3 cycles");
        applyStimulus(1'b1, 3);

        // Seven frame_starts (k=0..1728); strobes at the 3rd and 6th.
        count_en = 1'b1;
        applyStimulus(1'b0, 2016);
        #6;
        count_en = 1'b0;
        checkOutput("mover_pulses", mv_cnt, 2);
        checkOutput("frame_starts", fs_cnt, 7);
        checkOutput("hsync_cycles", hs_cnt, 252);
        checkOutput("vsync_cycles", vs_cnt, 336);
        checkOutput("video_on_cycles", von_cnt, 896);

        $display("[TB] mid-frame reset");
        applyStimulus(1'b0, 100);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 700);

`ifdef VGA_TESTPATTERN_EN
        $display("[TB] colour bars");
        test_mode = 1'b1;
        applyStimulus(1'b0, 300);
        test_mode = 1'b0;
        applyStimulus(1'b0, 30);
`endif

        @(negedge uclk);
        @(negedge uclk);
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
